ddr3_word_port: RTL and testbench

DDR3_WORD_PORT -- requirements
Module: ddr3_word_port

---
 rtl/ddr3_word_port.sv | 170 +++++++++++++++++
 tb/tb_ddr3_word_port.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_word_port.sv
// Word-to-line port: one-line write-through buffer, hit ack in 1 cycle, misses wait on line_ack_i; requests held until ack_o.
// Define WORD_PORT_LINEBUF_EN to let the buffer serve hits; otherwise every access goes to the line cache.
module ddr3_word_port (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  data_i,
    input  logic [3:0]   sel_i,
    input  logic         we_i,
    input  logic         rd_i,
    output logic [31:0]  data_o,
    output logic         ack_o,
    output logic [31:0]  line_addr_o,
    output logic [255:0] line_data_o,
    input  logic [255:0] line_data_i,
    output logic         line_we_o,
    output logic         line_rd_o,
    input  logic         line_ack_i
);

    typedef enum logic [1:0] {IDLE, FETCH, STORE, DONE} state_t;

`ifdef WORD_PORT_LINEBUF_EN
    localparam logic KEEP_VALID = 1'b1;
`else
    localparam logic KEEP_VALID = 1'b0;
`endif

    state_t         state_q, state_d;
    logic [255:0]   buf_q, buf_d;
    logic [26:0]    tag_q, tag_d;
    logic           valid_q, valid_d;
    logic           is_wr_q, is_wr_d;
    logic [2:0]     word_q, word_d;
    logic [31:0]    wdat_q, wdat_d;
    logic [3:0]     wsel_q, wsel_d;
    logic [31:0]    line_addr_q, line_addr_d;
    logic [255:0]   line_data_q, line_data_d;
    logic           line_rd_q, line_rd_d;
    logic           line_we_q, line_we_d;
    logic [31:0]    data_q, data_d;
    logic           hit;

    function automatic logic [255:0] merge_word(input logic [255:0] line, input logic [2:0] w,
                                                input logic [31:0] d, input logic [3:0] s);
        logic [255:0] r;
        r = line;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[{w, 5'd0} + 8'(8 * b) +: 8] = d[8 * b +: 8];
        end
        return r;
    endfunction

    assign hit = valid_q && (tag_q == addr_i[31:5]);

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        is_wr_d     = is_wr_q;
        word_d      = word_q;
        wdat_d      = wdat_q;
        wsel_d      = wsel_q;
        line_addr_d = line_addr_q;
        line_data_d = line_data_q;
        line_rd_d   = line_rd_q;
        line_we_d   = line_we_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                // a simultaneous read+write is handled as a write
                if (we_i) begin
                    is_wr_d = 1'b1;
                    word_d  = addr_i[4:2];
                    wdat_d  = data_i;
                    wsel_d  = sel_i;
                    if (sel_i == 4'b0000) begin
                        state_d = DONE;
                    end else if (hit) begin
                        buf_d       = merge_word(buf_q, addr_i[4:2], data_i, sel_i);
                        line_data_d = buf_d;
                        line_addr_d = {addr_i[31:5], 5'd0};
                        line_we_d   = 1'b1;
                        state_d     = STORE;
                    end else begin
                        line_addr_d = {addr_i[31:5], 5'd0};
                        line_rd_d   = 1'b1;
                        state_d     = FETCH;
                    end
                end else if (rd_i) begin
                    is_wr_d = 1'b0;
                    word_d  = addr_i[4:2];
                    if (hit) begin
                        data_d  = buf_q[{addr_i[4:2], 5'd0} +: 32];
                        state_d = DONE;
                    end else begin
                        line_addr_d = {addr_i[31:5], 5'd0};
                        line_rd_d   = 1'b1;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                if (line_ack_i) begin
                    line_rd_d = 1'b0;
                    tag_d     = line_addr_q[31:5];
                    valid_d   = KEEP_VALID;
                    if (is_wr_q) begin
                        buf_d       = merge_word(line_data_i, word_q, wdat_q, wsel_q);
                        line_data_d = buf_d;
                        line_we_d   = 1'b1;
                        state_d     = STORE;
                    end else begin
                        buf_d   = line_data_i;
                        data_d  = line_data_i[{word_q, 5'd0} +: 32];
                        state_d = DONE;
                    end
                end
            end
            STORE: begin
                if (line_ack_i) begin
                    line_we_d = 1'b0;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wdat_q      <= '0;
            wsel_q      <= '0;
            line_addr_q <= '0;
            line_data_q <= '0;
            line_rd_q   <= 1'b0;
            line_we_q   <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            wdat_q      <= wdat_d;
            wsel_q      <= wsel_d;
            line_addr_q <= line_addr_d;
            line_data_q <= line_data_d;
            line_rd_q   <= line_rd_d;
            line_we_q   <= line_we_d;
            data_q      <= data_d;
        end
    end

    assign ack_o       = (state_q == DONE);
    assign data_o      = data_q;
    assign line_addr_o = line_addr_q;
    assign line_data_o = line_data_q;
    assign line_rd_o   = line_rd_q;
    assign line_we_o   = line_we_q;

endmodule

// File: tb/tb_ddr3_word_port.sv
// Bench for ddr3_word_port: directed scenarios plus random traffic against a one-line buffer model.
module tb_ddr3_word_port;

`ifdef WORD_PORT_LINEBUF_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [31:0]  data_i = '0;
    logic [3:0]   sel_i = '0;
    logic         we_i = 1'b0;
    logic         rd_i = 1'b0;
    logic [31:0]  data_o;
    logic         ack_o;
    logic [31:0]  line_addr_o;
    logic [255:0] line_data_o;
    logic [255:0] line_data_i = '0;
    logic         line_we_o;
    logic         line_rd_o;
    logic         line_ack_i = 1'b0;

    ddr3_word_port dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i),
        .we_i(we_i), .rd_i(rd_i), .data_o(data_o), .ack_o(ack_o),
        .line_addr_o(line_addr_o), .line_data_o(line_data_o), .line_data_i(line_data_i),
        .line_we_o(line_we_o), .line_rd_o(line_rd_o), .line_ack_i(line_ack_i)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // line cache environment
    logic [255:0] env_mem [bit [26:0]];
    int           rd_cnt = 0, we_cnt = 0, lack_cyc = 0, wait_cnt = 0;
    logic [31:0]  last_rd_addr = '0, last_we_addr = '0;
    logic [255:0] last_we_data = '0;
    bit           hold = 1'b0;

    // reference model: one buffered line plus expected memory image
    bit           mvalid = 1'b0;
    logic [26:0]  mtag = '0;
    logic [255:0] mbuf = '0;
    logic [255:0] ref_mem [bit [26:0]];

    function automatic logic [255:0] dflt(input logic [26:0] t);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32 * k +: 32] = 32'hC000_0000 ^ {t[23:0], 3'(k), 5'd0};
        return l;
    endfunction

    function automatic logic [255:0] env_line(input logic [26:0] t);
        return env_mem.exists(t) ? env_mem[t] : dflt(t);
    endfunction

    function automatic logic [255:0] ref_line(input logic [26:0] t);
        return ref_mem.exists(t) ? ref_mem[t] : dflt(t);
    endfunction

    always @(negedge clk) begin
        line_ack_i = 1'b0;
        if (line_rd_o || line_we_o) begin
            vectors++;
            if (line_rd_o && line_we_o) begin
                miscompares++;
                $display("FAIL both_line_req: rd=%b we=%b, required not both 1", line_rd_o, line_we_o);
            end
        end
        if (rst && !hold && (line_rd_o || line_we_o)) begin
            if (wait_cnt > 0) wait_cnt--;
            else begin
                line_ack_i = 1'b1;
                lack_cyc   = cyc;
                wait_cnt   = $urandom_range(0, 3);
                if (line_rd_o) begin
                    rd_cnt++;
                    last_rd_addr = line_addr_o;
                    line_data_i  = env_line(line_addr_o[31:5]);
                end else begin
                    we_cnt++;
                    last_we_addr = line_addr_o;
                    last_we_data = line_data_o;
                    env_mem[line_addr_o[31:5]] = line_data_o;
                end
            end
        end
    end

    function automatic void model_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                      input bit w, output int erd, output int ewe,
                                      output logic [255:0] ewd, output logic [31:0] edo);
        logic [26:0] t;
        int k;
        t = a[31:5];
        k = int'(a[4:2]);
        erd = 0; ewe = 0; ewd = '0; edo = '0;
        if (w && s == 4'b0000) return;
        if (!(EN && mvalid && mtag == t)) begin
            erd = 1; mbuf = ref_line(t); mtag = t; mvalid = 1'b1;
        end
        if (w) begin
            for (int b = 0; b < 4; b++) if (s[b]) mbuf[32 * k + 8 * b +: 8] = d[8 * b +: 8];
            ewe = 1; ewd = mbuf; ref_mem[t] = mbuf;
        end else begin
            edo = mbuf[32 * k +: 32];
        end
    endfunction

    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit w, input bit r, output int n, output int drd, output int dwe,
                           output logic [31:0] dout, output bit ack_ok, output int since_lack,
                           output logic ack_after);
        int rd0, we0;
        rd0 = rd_cnt; we0 = we_cnt;
        @(negedge clk);
        addr_i = a; data_i = d; sel_i = s; we_i = w; rd_i = r;
        n = 0; ack_ok = 1'b0;
        while (n < 60 && !ack_ok) begin
            @(posedge clk); #1;
            n++;
            if (ack_o === 1'b1) ack_ok = 1'b1;
        end
        dout = data_o;
        since_lack = cyc - lack_cyc;
        we_i = 1'b0; rd_i = 1'b0;
        @(posedge clk); #1;
        ack_after = ack_o;
        drd = rd_cnt - rd0;
        dwe = we_cnt - we0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL rst_ack: got %b want 0", ack_o); end
        vectors++; if (line_rd_o !== 1'b0) begin miscompares++; $display("FAIL rst_line_rd: got %b want 0", line_rd_o); end
        vectors++; if (line_we_o !== 1'b0) begin miscompares++; $display("FAIL rst_line_we: got %b want 0", line_we_o); end
        vectors++; if (line_addr_o !== 32'h0) begin miscompares++; $display("FAIL rst_line_addr: got %h want 0", line_addr_o); end
        vectors++; if (line_data_o !== 256'h0) begin miscompares++; $display("FAIL rst_line_data: got %h want 0", line_data_o); end
        vectors++; if (data_o !== 32'h0) begin miscompares++; $display("FAIL rst_data: got %h want 0", data_o); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_read_miss();
        int n, drd, dwe, erd, ewe, sl;
        logic [31:0] dout, edo;
        logic [255:0] ewd, l;
        bit ok;
        logic aa;
        for (int k = 0; k < 8; k++) l[32 * k +: 32] = 32'h1000_0000 + 32'(k);
        env_mem[27'd2] = l;
        ref_mem[27'd2] = l;
        model_txn(32'h44, 32'h0, 4'h0, 1'b0, erd, ewe, ewd, edo);
        run_txn(32'h44, 32'h0, 4'h0, 1'b0, 1'b1, n, drd, dwe, dout, ok, sl, aa);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rdmiss_ack: got %b want 1", ok); end
        vectors++; if (drd !== erd) begin miscompares++; $display("FAIL rdmiss_line_rd: got %0d want %0d", drd, erd); end
        vectors++; if (last_rd_addr !== 32'h40) begin miscompares++; $display("FAIL rdmiss_addr: got %h want 00000040", last_rd_addr); end
        vectors++; if (sl !== 1) begin miscompares++; $display("FAIL rdmiss_latency: got %0d want 1", sl); end
        vectors++; if (dout !== 32'h1000_0001) begin miscompares++; $display("FAIL rdmiss_data: got %h want 10000001", dout); end
        vectors++; if (aa !== 1'b0) begin miscompares++; $display("FAIL rdmiss_ack_pulse: got %b want 0", aa); end
    endtask

    task automatic test_read_hit();
        int n, drd, dwe, erd, ewe, sl;
        logic [31:0] dout, edo;
        logic [255:0] ewd;
        bit ok;
        logic aa;
        model_txn(32'h58, 32'h0, 4'h0, 1'b0, erd, ewe, ewd, edo);
        run_txn(32'h58, 32'h0, 4'h0, 1'b0, 1'b1, n, drd, dwe, dout, ok, sl, aa);
        vectors++; if (drd !== erd) begin miscompares++; $display("FAIL rdhit_line_rd: got %0d want %0d", drd, erd); end
        vectors++; if (dout !== 32'h1000_0006) begin miscompares++; $display("FAIL rdhit_data: got %h want 10000006", dout); end
        if (erd == 0) begin
            vectors++; if (n !== 1) begin miscompares++; $display("FAIL rdhit_latency: got %0d want 1", n); end
        end else begin
            vectors++; if (sl !== 1) begin miscompares++; $display("FAIL rdhit_latency: got %0d want 1", sl); end
        end
    endtask

    task automatic test_write_hit();
        int n, drd, dwe, erd, ewe, sl;
        logic [31:0] dout, edo;
        logic [255:0] ewd;
        bit ok;
        logic aa;
        model_txn(32'h48, 32'hAABBCCDD, 4'b0101, 1'b1, erd, ewe, ewd, edo);
        run_txn(32'h48, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0, n, drd, dwe, dout, ok, sl, aa);
        vectors++; if (dwe !== 1) begin miscompares++; $display("FAIL wrhit_line_we: got %0d want 1", dwe); end
        vectors++; if (drd !== erd) begin miscompares++; $display("FAIL wrhit_line_rd: got %0d want %0d", drd, erd); end
        vectors++; if (last_we_addr !== 32'h40) begin miscompares++; $display("FAIL wrhit_addr: got %h want 00000040", last_we_addr); end
        vectors++; if (last_we_data[95:64] !== 32'h10BB00DD) begin miscompares++; $display("FAIL wrhit_word2: got %h want 10bb00dd", last_we_data[95:64]); end
        vectors++; if (last_we_data !== ewd) begin miscompares++; $display("FAIL wrhit_line: got %h want %h", last_we_data, ewd); end
        vectors++; if (sl !== 1) begin miscompares++; $display("FAIL wrhit_latency: got %0d want 1", sl); end
    endtask

    task automatic test_write_miss();
        int n, drd, dwe, erd, ewe, sl;
        logic [31:0] dout, edo;
        logic [255:0] ewd;
        bit ok;
        logic aa;
        model_txn(32'h1000, 32'h12345678, 4'hF, 1'b1, erd, ewe, ewd, edo);
        run_txn(32'h1000, 32'h12345678, 4'hF, 1'b1, 1'b0, n, drd, dwe, dout, ok, sl, aa);
        vectors++; if (drd !== 1) begin miscompares++; $display("FAIL wrmiss_fetch: got %0d want 1", drd); end
        vectors++; if (dwe !== 1) begin miscompares++; $display("FAIL wrmiss_store: got %0d want 1", dwe); end
        vectors++; if (last_we_addr !== 32'h1000) begin miscompares++; $display("FAIL wrmiss_addr: got %h want 00001000", last_we_addr); end
        vectors++; if (last_we_data[31:0] !== 32'h12345678) begin miscompares++; $display("FAIL wrmiss_word0: got %h want 12345678", last_we_data[31:0]); end
        vectors++; if (last_we_data !== ewd) begin miscompares++; $display("FAIL wrmiss_line: got %h want %h", last_we_data, ewd); end
    endtask

    task automatic test_rw_sel0();
        int n, drd, dwe, erd, ewe, sl;
        logic [31:0] dout, edo;
        logic [255:0] ewd;
        bit ok;
        logic aa;
        model_txn(32'h40, 32'hDEADBEEF, 4'h0, 1'b1, erd, ewe, ewd, edo);
        run_txn(32'h40, 32'hDEADBEEF, 4'h0, 1'b1, 1'b1, n, drd, dwe, dout, ok, sl, aa);
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL sel0_latency: got %0d want 1", n); end
        vectors++; if (drd + dwe !== 0) begin miscompares++; $display("FAIL sel0_line_access: got %0d want 0", drd + dwe); end
    endtask

    task automatic test_random();
        logic [26:0] tags [4];
        tags[0] = 27'd2; tags[1] = 27'h80; tags[2] = 27'h81; tags[3] = 27'h3FF;
        for (int i = 0; i < 60; i++) begin
            int n, drd, dwe, erd, ewe, sl, mode;
            logic [31:0] a, d, dout, edo;
            logic [3:0] s;
            logic [255:0] ewd;
            bit ok, w, r;
            logic aa;
            a = {tags[$urandom_range(0, 3)], 5'($urandom)};
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            mode = $urandom_range(0, 2);
            w = (mode != 0);
            r = (mode != 1);
            model_txn(a, d, s, w, erd, ewe, ewd, edo);
            run_txn(a, d, s, w, r, n, drd, dwe, dout, ok, sl, aa);
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_ack: got %b want 1", i, ok); end
            vectors++; if (drd !== erd) begin miscompares++; $display("FAIL rnd%0d_line_rd: got %0d want %0d", i, drd, erd); end
            vectors++; if (dwe !== ewe) begin miscompares++; $display("FAIL rnd%0d_line_we: got %0d want %0d", i, dwe, ewe); end
            vectors++; if (aa !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_ack_pulse: got %b want 0", i, aa); end
            if (ewe != 0) begin
                vectors++; if (last_we_data !== ewd) begin miscompares++; $display("FAIL rnd%0d_wline: got %h want %h", i, last_we_data, ewd); end
                vectors++; if (last_we_addr !== {a[31:5], 5'd0}) begin miscompares++; $display("FAIL rnd%0d_waddr: got %h want %h", i, last_we_addr, {a[31:5], 5'd0}); end
            end
            if (!w) begin
                vectors++; if (dout !== edo) begin miscompares++; $display("FAIL rnd%0d_data: got %h want %h", i, dout, edo); end
            end
            if (erd + ewe != 0) begin
                vectors++; if (sl !== 1) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d want 1", i, sl); end
            end else begin
                vectors++; if (n !== 1) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d want 1", i, n); end
            end
        end
    endtask

    task automatic test_reset_abort();
        int n, drd, dwe, erd, ewe, sl, guard;
        logic [31:0] dout, edo;
        logic [255:0] ewd;
        bit ok;
        logic aa;
        hold = 1'b1;
        @(negedge clk);
        addr_i = 32'h2000; rd_i = 1'b1; we_i = 1'b0;
        guard = 0;
        while (guard < 10 && line_rd_o !== 1'b1) begin @(posedge clk); #1; guard++; end
        vectors++; if (line_rd_o !== 1'b1) begin miscompares++; $display("FAIL abort_req: got %b want 1", line_rd_o); end
        #2 rst = 1'b0;
        #1;
        vectors++; if (line_rd_o !== 1'b0) begin miscompares++; $display("FAIL abort_line_rd: got %b want 0", line_rd_o); end
        vectors++; if (line_addr_o !== 32'h0) begin miscompares++; $display("FAIL abort_line_addr: got %h want 0", line_addr_o); end
        mvalid = 1'b0;
        @(negedge clk);
        rd_i = 1'b0; hold = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_txn(32'h2004, 32'h0, 4'h0, 1'b0, erd, ewe, ewd, edo);
        run_txn(32'h2004, 32'h0, 4'h0, 1'b0, 1'b1, n, drd, dwe, dout, ok, sl, aa);
        vectors++; if (drd !== 1) begin miscompares++; $display("FAIL abort_remiss: got %0d want 1", drd); end
        vectors++; if (dout !== edo) begin miscompares++; $display("FAIL abort_data: got %h want %h", dout, edo); end
        model_txn(32'h48, 32'h0, 4'h0, 1'b0, erd, ewe, ewd, edo);
        run_txn(32'h48, 32'h0, 4'h0, 1'b0, 1'b1, n, drd, dwe, dout, ok, sl, aa);
        vectors++; if (dout !== edo) begin miscompares++; $display("FAIL abort_old_line: got %h want %h", dout, edo); end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_rw_sel0();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
